// File: rtl/bmp280_pkg.sv
// Shared encodings for the BMP280 forced-mode sequencer: engine opcodes, error codes,
// FSM states and the layout of the command program ROM.
package bmp280_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_CHIP_ID = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_CFG,
        ST_WAIT,
        ST_DATA,
        ST_DONE,
        ST_ERR_STOP
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_RESP,
        PH_GAP
    } phase_t;

    localparam logic [7:0] REG_CHIP_ID   = 8'hD0;
    localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
    localparam logic [7:0] REG_PRESS_MSB = 8'hF7;
    localparam logic [7:0] CHIP_ID       = 8'h58;

    localparam int unsigned STEP_W   = 5;
    localparam int unsigned ID_LEN   = 7;
    localparam int unsigned CFG_LEN  = 5;
    localparam int unsigned DATA_LEN = 12;

    localparam logic [STEP_W-1:0] ID_BASE       = '0;
    localparam logic [STEP_W-1:0] CFG_BASE      = ID_BASE + STEP_W'(ID_LEN);
    localparam logic [STEP_W-1:0] DATA_BASE     = CFG_BASE + STEP_W'(CFG_LEN);
    localparam logic [STEP_W-1:0] DATA_LAST     = DATA_BASE + STEP_W'(DATA_LEN - 1);
    // The ID program ends in a plain STOP, reused as the error-recovery STOP.
    localparam logic [STEP_W-1:0] ERR_STOP_STEP = ID_BASE + STEP_W'(ID_LEN - 1);

endpackage

// File: rtl/bmp280_cmd_rom.sv
// Command program ROM: maps the sequencer step counter to one I2C engine command.
module bmp280_cmd_rom
    import bmp280_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR  = 7'h77,
    parameter logic [7:0] CTRL_MEAS = 8'h25
) (
    input  logic [STEP_W-1:0] step,
    output cmd_op_t           op,
    output logic [7:0]        data,
    output logic              nack,
    output logic              last
);

    localparam logic [7:0] ADDR_WR = {I2C_ADDR, 1'b0};
    localparam logic [7:0] ADDR_RD = {I2C_ADDR, 1'b1};

    always_comb begin
        op   = OP_START;
        data = '0;
        nack = 1'b0;
        last = 1'b0;
        case (step)
            ID_BASE + 5'd1:   begin op = OP_WRITE; data = ADDR_WR;     end
            ID_BASE + 5'd2:   begin op = OP_WRITE; data = REG_CHIP_ID; end
            ID_BASE + 5'd4:   begin op = OP_WRITE; data = ADDR_RD;     end
            ID_BASE + 5'd5:   begin op = OP_READ;  nack = 1'b1;        end
            ID_BASE + 5'd6:   begin op = OP_STOP;  last = 1'b1;        end
            CFG_BASE + 5'd1:  begin op = OP_WRITE; data = ADDR_WR;       end
            CFG_BASE + 5'd2:  begin op = OP_WRITE; data = REG_CTRL_MEAS; end
            CFG_BASE + 5'd3:  begin op = OP_WRITE; data = CTRL_MEAS;     end
            CFG_BASE + 5'd4:  begin op = OP_STOP;  last = 1'b1;          end
            DATA_BASE + 5'd1: begin op = OP_WRITE; data = ADDR_WR;       end
            DATA_BASE + 5'd2: begin op = OP_WRITE; data = REG_PRESS_MSB; end
            DATA_BASE + 5'd4: begin op = OP_WRITE; data = ADDR_RD;       end
            DATA_BASE + 5'd5, DATA_BASE + 5'd6, DATA_BASE + 5'd7,
            DATA_BASE + 5'd8, DATA_BASE + 5'd9: op = OP_READ;
            DATA_BASE + 5'd10: begin op = OP_READ; nack = 1'b1; end
            DATA_LAST:         begin op = OP_STOP; last = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/bmp280_sequencer.sv
// BMP280 forced-mode measurement sequencer driving a byte-level I2C command engine;
// verifies the chip ID once, then per trigger configures, waits and burst-reads raw P/T.
module bmp280_sequencer
    import bmp280_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR       = 7'h77,
    parameter logic [7:0]  CTRL_MEAS      = 8'h25,
    parameter int unsigned CONV_CYCLES    = 500_000,
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        FPGA_CLK1_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        auto_en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_data,
    output logic        cmd_nack,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic        busy,
    output logic        sample_valid,
    output logic [19:0] raw_press,
    output logic [19:0] raw_temp,
    output logic        chip_ok,
    output logic        error,
    output logic [1:0]  err_code
);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [STEP_W-1:0] step_q, step_d;
    err_code_t         err_code_q, err_code_d;
    logic              error_q, error_d, chip_ok_q, chip_ok_d;
    logic [31:0]       timer_q, conv_q, period_q;
    logic [39:0]       shift_q;
    logic              timer_clr, capture, load_raw;

    cmd_op_t    rom_op;
    logic [7:0] rom_data;
    logic       rom_nack, rom_last;

    bmp280_cmd_rom #(
        .I2C_ADDR  (I2C_ADDR),
        .CTRL_MEAS (CTRL_MEAS)
    ) u_rom (
        .step (step_q),
        .op   (rom_op),
        .data (rom_data),
        .nack (rom_nack),
        .last (rom_last)
    );

    logic in_prog, period_hit, trigger, timed_out, nibble_rd;
    assign in_prog    = (state_q == ST_ID) || (state_q == ST_CFG) ||
                        (state_q == ST_DATA) || (state_q == ST_ERR_STOP);
    assign period_hit = auto_en && (period_q == PERIOD_CYCLES - 1);
    assign trigger    = start || period_hit;
    assign timed_out  = in_prog && (phase_q != PH_GAP) && (timer_q == TIMEOUT_CYCLES - 1);
    // F9 and FC contribute only their upper nibble (xlsb), so they shift in 4 bits.
    assign nibble_rd  = (step_q == DATA_BASE + 5'd7) || (step_q == DATA_BASE + 5'd10);

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_ISSUE;
            step_q     <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            chip_ok_q  <= 1'b0;
            timer_q    <= '0;
            conv_q     <= '0;
            period_q   <= '0;
            shift_q    <= '0;
            raw_press  <= '0;
            raw_temp   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            chip_ok_q  <= chip_ok_d;
            if (timer_clr)
                timer_q <= '0;
            else if (in_prog && phase_q != PH_GAP)
                timer_q <= timer_q + 32'd1;
            conv_q   <= (state_q == ST_WAIT) ? conv_q + 32'd1 : '0;
            period_q <= (!auto_en || period_hit) ? '0 : period_q + 32'd1;
            if (capture)
                shift_q <= nibble_rd ? {shift_q[35:0], rsp_data[7:4]} : {shift_q[31:0], rsp_data};
            if (load_raw) begin
                raw_press <= shift_q[39:20];
                raw_temp  <= shift_q[19:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        step_d     = step_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        chip_ok_d  = chip_ok_q;
        timer_clr  = 1'b0;
        capture    = 1'b0;
        load_raw   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    phase_d    = PH_ISSUE;
                    timer_clr  = 1'b1;
                    state_d    = chip_ok_q ? ST_CFG : ST_ID;
                    step_d     = chip_ok_q ? CFG_BASE : ID_BASE;
                end
            end
            ST_WAIT: begin
                if (conv_q == CONV_CYCLES - 1) begin
                    state_d   = ST_DATA;
                    step_d    = DATA_BASE;
                    phase_d   = PH_ISSUE;
                    timer_clr = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (timed_out) begin
                    state_d    = ST_IDLE;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    unique case (phase_q)
                        PH_ISSUE: if (cmd_ready) phase_d = PH_RESP;
                        PH_GAP: begin
                            phase_d   = PH_ISSUE;
                            timer_clr = 1'b1;
                        end
                        default: if (rsp_valid) begin
                            phase_d = PH_GAP;
                            step_d  = step_q + STEP_W'(1);
                            capture = (state_q == ST_DATA) && (rom_op == OP_READ);
                            if (state_q != ST_ERR_STOP && rom_op == OP_WRITE && rsp_nack) begin
                                state_d    = ST_ERR_STOP;
                                step_d     = ERR_STOP_STEP;
                                err_code_d = ERR_NACK;
                            end else if (state_q == ST_ID && rom_op == OP_READ && rsp_data != CHIP_ID) begin
                                state_d    = ST_ERR_STOP;
                                step_d     = ERR_STOP_STEP;
                                err_code_d = ERR_CHIP_ID;
                            end else begin
                                if (state_q == ST_ID && rom_op == OP_READ)
                                    chip_ok_d = 1'b1;
                                if (rom_last) begin
                                    unique case (state_q)
                                        ST_ID: begin
                                            state_d = ST_CFG;
                                            step_d  = CFG_BASE;
                                        end
                                        ST_CFG: state_d = ST_WAIT;
                                        ST_DATA: begin
                                            state_d  = ST_DONE;
                                            load_raw = 1'b1;
                                        end
                                        default: begin
                                            state_d = ST_IDLE;
                                            error_d = 1'b1;
                                        end
                                    endcase
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    assign cmd_valid    = in_prog && (phase_q == PH_ISSUE);
    assign cmd_op       = cmd_valid ? rom_op : OP_START;
    assign cmd_data     = cmd_valid ? rom_data : 8'h00;
    assign cmd_nack     = cmd_valid && rom_nack;
    assign busy         = (state_q != ST_IDLE);
    assign sample_valid = (state_q == ST_DONE);
    assign chip_ok      = chip_ok_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule
